// File: rtl/cpu_pkg.sv
// Shared CPU definitions: prefetch FSM states and memory read/write encodings.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } prefetch_state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/instr_prefetch_if.sv
// Prefetch bus: MemControl read handshake plus the CPU-facing IR queue head.
// The master modport is the prefetch unit's view.
interface instr_prefetch_if #(
    parameter int IWIDTH = 32,
    parameter int AWIDTH = 8
) ();

    logic [AWIDTH-1:0] mem_addr;
    logic              mem_rw;
    logic              mem_valid;
    logic              mem_ready;
    logic [IWIDTH-1:0] mem_data;

    logic              ir_pop;
    logic              ir_valid;
    logic [IWIDTH-1:0] ir_out;
    logic [AWIDTH-1:0] ir_pc;

    modport master (
        output mem_addr, mem_rw, mem_valid, ir_valid, ir_out, ir_pc,
        input  mem_ready, mem_data, ir_pop
    );

    modport slave (
        input  mem_addr, mem_rw, mem_valid, ir_valid, ir_out, ir_pc,
        output mem_ready, mem_data, ir_pop
    );

endinterface

// File: rtl/prefetch_fifo.sv
// Small circular FIFO holding {pc, instr} entries for the prefetch unit.
// clear empties the queue and takes priority over push and pop.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             popEn;

    assign popEn = pop && !empty;
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rdPtr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (popEn) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(popEn);
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; empty gates every read of it, so stale words are never visible.
        if (push && !clear) mem[wrPtr] <= wdata;
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: issues one read at a time to MemControl from
// successive addresses and queues {pc, instr} for the CPU. flush discards the
// queue and redirects fetching; a response still in flight is drained.
// Optional feature macro: PREFETCH_STATS_EN adds fetch_cnt / discard_cnt.
module instr_prefetch
    import cpu_pkg::*;
#(
    parameter int IWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              flush,
    input  logic [AWIDTH-1:0] flush_pc,
    instr_prefetch_if.master  bus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       discard_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    prefetch_state_t          state;
    prefetch_state_t          nextState;
    logic [AWIDTH-1:0]        fetchPc;
    logic                     doPush;
    logic                     doPop;
    logic                     canReq;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic [CW-1:0]            fifoCount;
    logic [AWIDTH+IWIDTH-1:0] headEntry;

    // Flush wins over pop and push; a response arriving with a flush is dropped.
    assign doPop  = bus.ir_pop && !fifoEmpty && !flush;
    // Requests are only issued with room, so the full guard never drops a real response.
    assign doPush = (state == WAIT) && bus.mem_ready && !flush && (!fifoFull || doPop);
    // Room is judged after any pop happening this same cycle.
    assign canReq = (fifoCount < CW'(DEPTH)) || doPop;

    assign bus.mem_addr = fetchPc;
    assign bus.mem_rw   = MEM_READ;
    assign bus.ir_valid = !fifoEmpty;
    assign bus.ir_out   = fifoEmpty ? '0 : headEntry[IWIDTH-1:0];
    assign bus.ir_pc    = fifoEmpty ? '0 : headEntry[IWIDTH +: AWIDTH];

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AWIDTH + IWIDTH)
    ) prefetchFifo (
        .clk   (clk),
        .reset (reset),
        .push  (doPush),
        .pop   (doPop),
        .clear (flush),
        .wdata ({fetchPc, bus.mem_data}),
        .rdata (headEntry),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state and request strobe.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        nextState     = state;
        bus.mem_valid = 1'b0;
        case (state)
            IDLE:  if (!flush && run && canReq) nextState = REQ;
            REQ: begin
                bus.mem_valid = 1'b1;
                nextState     = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (bus.mem_ready)  nextState = IDLE;
                else if (flush)     nextState = DRAIN;
            end
            DRAIN: if (bus.mem_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Fetch address: redirected by flush, advanced by each queued response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      fetchPc <= '0;
        else if (flush)  fetchPc <= flush_pc;
        else if (doPush) fetchPc <= fetchPc + 1'b1;
    end

`ifdef PREFETCH_STATS_EN
    logic respDiscard;

    // A response is discarded while draining, or when it meets a flush in WAIT.
    assign respDiscard = bus.mem_ready && ((state == DRAIN) || ((state == WAIT) && flush));

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt   <= '0;
            discard_cnt <= '0;
        end else begin
            if (doPush && (fetch_cnt != 16'hFFFF))        fetch_cnt   <= fetch_cnt + 16'd1;
            if (respDiscard && (discard_cnt != 16'hFFFF)) discard_cnt <= discard_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed testbench for instr_prefetch. The memory model answers each
// request two cycles after mem_valid with word = 32'hA000_0000 + address.
module tb_instr_prefetch;
    import cpu_pkg::*;

    localparam int IWIDTH = 32;
    localparam int AWIDTH = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              run = 1'b0;
    logic              flush = 1'b0;
    logic [AWIDTH-1:0] flushPc = '0;
`ifdef PREFETCH_STATS_EN
    logic [15:0]       fetchCnt;
    logic [15:0]       discardCnt;
`endif

    int                assertCount = 0;
    int                failCount = 0;
    int                reqCount = 0;
    int                respDelay = 0;
    logic [AWIDTH-1:0] lastReqAddr = '0;
    logic [AWIDTH-1:0] pendAddr = '0;

    instr_prefetch_if #(.IWIDTH(IWIDTH), .AWIDTH(AWIDTH)) bus ();

    instr_prefetch #(
        .IWIDTH (IWIDTH),
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .flush       (flush),
        .flush_pc    (flushPc),
        .bus         (bus.master)
`ifdef PREFETCH_STATS_EN
        ,
        .fetch_cnt   (fetchCnt),
        .discard_cnt (discardCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordAt(input logic [AWIDTH-1:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Check the queue head, then consume it.
    task automatic popCheck(input string tag, input logic [AWIDTH-1:0] pc);
        checkVal({tag, "_valid"}, 32'(bus.ir_valid), 32'd1);
        checkVal({tag, "_pc"}, 32'(bus.ir_pc), 32'(pc));
        checkVal({tag, "_data"}, bus.ir_out, wordAt(pc));
        bus.ir_pop = 1'b1;
        tick();
        bus.ir_pop = 1'b0;
    endtask

    task automatic waitCount(input int target);
        for (int i = 0; i < 200; i++) begin
            if (32'(dut.prefetchFifo.count) == target) break;
            tick();
        end
    endtask

    // MemControl model: one outstanding read, ready two cycles after mem_valid.
    initial begin : memModel
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (!reset) begin
                respDelay = 0;
            end else if (respDelay > 0) begin
                respDelay--;
                if (respDelay == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_data  = wordAt(pendAddr);
                end
            end else if (bus.mem_valid) begin
                reqCount++;
                lastReqAddr = bus.mem_addr;
                pendAddr    = bus.mem_addr;
                respDelay   = 2;
            end
        end
    end

    initial begin : stimulus
        bus.ir_pop    = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;

        // Reset state
        tick(3);
        checkVal("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        checkVal("rst_ir_out", bus.ir_out, 32'd0);
        checkVal("rst_ir_pc", 32'(bus.ir_pc), 32'd0);
        checkVal("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        checkVal("rst_mem_rw", 32'(bus.mem_rw), 32'(MEM_READ));
        checkVal("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
`ifdef PREFETCH_STATS_EN
        checkVal("rst_fetch_cnt", 32'(fetchCnt), 32'd0);
`endif
        reset = 1'b1;
        tick();

        // 1: fill the queue with addresses 0..3, no further request while full
        run = 1'b1;
        waitCount(4);
        checkVal("t1_full_count", 32'(dut.prefetchFifo.count), 32'd4);
        tick(20);
        checkVal("t1_no_5th_req", reqCount, 32'd4);
        checkVal("t1_head_pc", 32'(bus.ir_pc), 32'd0);
        checkVal("t1_head_data", bus.ir_out, 32'hA000_0000);

        // 2: one pop while full gives exactly one more request, address 4
        bus.ir_pop = 1'b1;
        tick();
        bus.ir_pop = 1'b0;
        checkVal("t2_head_after_pop", 32'(bus.ir_pc), 32'd1);
        waitCount(4);
        tick(20);
        checkVal("t2_one_req", reqCount, 32'd5);
        checkVal("t2_req_addr", 32'(lastReqAddr), 32'd4);
        run = 1'b0;
        tick(2);
        popCheck("t2_e1", 8'd1);
        popCheck("t2_e2", 8'd2);
        popCheck("t2_e3", 8'd3);
        checkVal("t2_tail_pc", 32'(bus.ir_pc), 32'd4);
        checkVal("t2_tail_data", bus.ir_out, 32'hA000_0004);

        // 3: flush during WAIT for address 5
        run = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.mem_valid && bus.mem_addr == 8'd5) break;
        end
        checkVal("t3_req5_addr", 32'(bus.mem_addr), 32'd5);
        tick();
        flush   = 1'b1;
        flushPc = 8'h40;
        tick();
        flush = 1'b0;
        checkVal("t3_flush_clears", 32'(bus.ir_valid), 32'd0);
        for (int i = 0; i < 50; i++) begin
            if (bus.mem_valid) break;
            tick();
        end
        checkVal("t3_redirect_addr", 32'(bus.mem_addr), 32'h40);
        for (int i = 0; i < 50; i++) begin
            if (bus.ir_valid) break;
            tick();
        end
        checkVal("t3_first_pc", 32'(bus.ir_pc), 32'h40);
        checkVal("t3_first_data", bus.ir_out, 32'hA000_0040);
`ifdef PREFETCH_STATS_EN
        checkVal("t3_discard_cnt", 32'(discardCnt), 32'd1);
        checkVal("t3_fetch_cnt", 32'(fetchCnt), 32'd6);
`endif
        run = 1'b0;
        tick(10);

        // 4: address wrap from 8'hFE
        flush   = 1'b1;
        flushPc = 8'hFE;
        tick();
        flush = 1'b0;
        checkVal("t4_flush_idle_clears", 32'(bus.ir_valid), 32'd0);
        run = 1'b1;
        waitCount(4);
        run = 1'b0;
        tick(10);
        popCheck("t4_fe", 8'hFE);
        popCheck("t4_ff", 8'hFF);
        popCheck("t4_00", 8'h00);
        popCheck("t4_01", 8'h01);
        checkVal("t4_empty", 32'(bus.ir_valid), 32'd0);

        // 5: push and pop in the same cycle at count 2
        flush   = 1'b1;
        flushPc = 8'h10;
        tick();
        flush = 1'b0;
        run   = 1'b1;
        waitCount(2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.mem_ready) break;
        end
        checkVal("t5_pre_count", 32'(dut.prefetchFifo.count), 32'd2);
        bus.ir_pop = 1'b1;
        run        = 1'b0;
        tick();
        bus.ir_pop = 1'b0;
        checkVal("t5_count_same", 32'(dut.prefetchFifo.count), 32'd2);
        popCheck("t5_head", 8'h11);
        checkVal("t5_next_pc", 32'(bus.ir_pc), 32'h12);
        checkVal("t5_next_data", bus.ir_out, 32'hA000_0012);

        // 6: reset asserted while waiting for a response
        run = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.mem_valid) break;
        end
        checkVal("t6_req_addr", 32'(bus.mem_addr), 32'h13);
        tick();
        reset = 1'b0;
        #1;
        checkVal("t6_ir_valid", 32'(bus.ir_valid), 32'd0);
        checkVal("t6_ir_out", bus.ir_out, 32'd0);
        checkVal("t6_ir_pc", 32'(bus.ir_pc), 32'd0);
        checkVal("t6_mem_valid", 32'(bus.mem_valid), 32'd0);
        checkVal("t6_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkVal("t6_mem_rw", 32'(bus.mem_rw), 32'(MEM_READ));
`ifdef PREFETCH_STATS_EN
        checkVal("t6_fetch_cnt", 32'(fetchCnt), 32'd0);
        checkVal("t6_discard_cnt", 32'(discardCnt), 32'd0);
`endif
        run = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        checkVal("t6_idle_after", 32'(bus.mem_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
